uart_tx_queue: RTL

Byte queue and launch sequencer sitting directly upstream of the UART transmitter. Accepts bytes from a producer at up to one per clock, buffers them in a DEPTH-entry FIFO, and feeds them to the transmitter one at a time using its data-valid / active / done handshake. An optional inter-byte idle gap is enforced after each completed frame.

---
 rtl/uart_tx_queue_if.sv | 38 +++
 rtl/uart_tx_queue.sv | 94 +++++++++
 2 files changed

// File: rtl/uart_tx_queue_if.sv
// rtl/uart_tx_queue_if.sv - producer and transmitter handshake bundle for uart_tx_queue
// o_Drop_Count exists only when UART_TXQ_DROP_CNT_EN is defined.
interface uart_tx_queue_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_Wr_DV;
  logic [7:0]    i_Wr_Byte;
  logic          o_Full;
  logic          o_Empty;
  logic [CW-1:0] o_Count;
  logic          o_TX_DV;
  logic [7:0]    o_TX_Byte;
  logic          i_TX_Active;
  logic          i_TX_Done;
`ifdef UART_TXQ_DROP_CNT_EN
  logic [7:0]    o_Drop_Count;

  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
    output o_Full, o_Empty, o_Count, o_TX_DV, o_TX_Byte, o_Drop_Count
  );
  modport master (
    output i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
    input  o_Full, o_Empty, o_Count, o_TX_DV, o_TX_Byte, o_Drop_Count
  );
`else
  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
    output o_Full, o_Empty, o_Count, o_TX_DV, o_TX_Byte
  );
  modport master (
    output i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
    input  o_Full, o_Empty, o_Count, o_TX_DV, o_TX_Byte
  );
`endif
endinterface

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO and launch sequencer feeding a UART transmitter
// Optional drop counter enabled by defining UART_TXQ_DROP_CNT_EN.
module uart_tx_queue #(
  parameter int DEPTH    = 16,
  parameter int GAP_CLKS = 0
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  uart_tx_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_next;
  logic [GW-1:0] gap_cnt;
  logic          wr_accept;
  logic          pop;
  logic          gap_done;

  // Full is the registered flag, so a same-edge pop never makes room for a write.
  assign wr_accept = q.i_Wr_DV && !q.o_Full;
  assign pop       = (state == IDLE) && !q.o_Empty && !q.i_TX_Active;
  assign gap_done  = (gap_cnt == GW'(GAP_CLKS - 1));

  always_comb begin
    count_next = q.o_Count;
    case ({wr_accept, pop})
      2'b10:   count_next = q.o_Count + CW'(1);
      2'b01:   count_next = q.o_Count - CW'(1);
      default: count_next = q.o_Count;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = LAUNCH;
      LAUNCH:  state_next = BUSY;
      BUSY:    if (q.i_TX_Done) state_next = (GAP_CLKS > 0) ? GAP : IDLE;
      GAP:     if (gap_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge i_Clock) begin
    if (wr_accept) mem[wr_ptr] <= q.i_Wr_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q.o_Count   <= '0;
      q.o_Full    <= 1'b0;
      q.o_Empty   <= 1'b1;
      q.o_TX_DV   <= 1'b0;
      q.o_TX_Byte <= 8'h00;
      gap_cnt     <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        q.o_TX_Byte <= mem[rd_ptr];
      end
      q.o_Count <= count_next;
      q.o_Full  <= (count_next == CW'(DEPTH));
      q.o_Empty <= (count_next == '0);
      q.o_TX_DV <= pop;
      gap_cnt   <= (state == GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

`ifdef UART_TXQ_DROP_CNT_EN
  always_ff @(posedge i_Clock) begin
    if (i_Reset)
      q.o_Drop_Count <= 8'h00;
    else if (q.i_Wr_DV && q.o_Full && q.o_Drop_Count != 8'hFF)
      q.o_Drop_Count <= q.o_Drop_Count + 8'h01;
  end
`endif
endmodule
